// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 registered channel selector.
// The round-robin helper is only referenced when MUX_RR_EN is defined.
package mux_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   // Index of the channel that follows idx, wrapping back to 0 after n_ch-1.
   function automatic int rr_next(input int idx, input int n_ch);
      return (idx == n_ch - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mux_rr_arb.sv
// Combinational round-robin arbiter for mux_n_1_rr.
// Picks the first valid channel at or after ptr, wrapping modulo N_CH.
// The pointer register lives in the parent; this block holds no state.
module mux_rr_arb
   import mux_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int SELW = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] valid,
   input  logic [SELW-1:0] ptr,
   output logic            gnt_vld,
   output logic [SELW-1:0] gnt_idx
);

   int            cand;
   logic [SELW-1:0] cand_idx;

   // Scan offsets from farthest to nearest so the channel closest to ptr wins.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_idx  = '0;
      cand     = 0;
      cand_idx = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         cand = int'(ptr) + k;
         if (cand >= N_CH) begin
            cand = cand - N_CH;
         end
         cand_idx = SELW'(cand);
         if (valid[cand_idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand_idx;
         end
      end
   end

endmodule

// File: rtl/mux_n_1_rr.sv
// N-channel, WIDTH-bit registered selector with valid/ready on every side.
// A source is chosen by sel_in, or by round-robin when MUX_RR_EN is defined
// and mode_in selects MODE_RR. Without MUX_RR_EN the block is select-only
// and mode_in is ignored.
module mux_n_1_rr
   import mux_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int WIDTH = 8,
   parameter int SELW  = $clog2(N_CH)
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [N_CH*WIDTH-1:0] d_in,
   input  logic [N_CH-1:0]       valid_in,
   output logic [N_CH-1:0]       ready_out,
   input  logic [SELW-1:0]       sel_in,
   input  logic                  mode_in,
   output logic [WIDTH-1:0]      y_out,
   output logic [SELW-1:0]       ch_out,
   output logic                  valid_out,
   input  logic                  ready_in
);

   logic             load_ok;
   logic             sel_vld;
   logic [SELW-1:0]  sel_idx;
   logic             grant_vld;
   logic [SELW-1:0]  grant_idx;
   logic [WIDTH-1:0] grant_data;
   logic             xfer;

   // The output register can accept a word when empty or being drained now.
   assign load_ok = !valid_out || ready_in;

   // Explicit select: only an in-range, valid channel produces a grant.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      for (int i = 0; i < N_CH; i++) begin
         if ((sel_in == SELW'(i)) && valid_in[i]) begin
            sel_vld = 1'b1;
            sel_idx = SELW'(i);
         end
      end
   end

`ifdef MUX_RR_EN
   logic [SELW-1:0] ptr;
   logic            rr_vld;
   logic [SELW-1:0] rr_idx;

   mux_rr_arb #(
      .N_CH (N_CH),
      .SELW (SELW)
   ) u_arb (
      .valid   (valid_in),
      .ptr     (ptr),
      .gnt_vld (rr_vld),
      .gnt_idx (rr_idx)
   );

   // Mode picks between the arbiter and the explicit select each cycle.
   always_comb begin
      grant_vld = sel_vld;
      grant_idx = sel_idx;
      if (mode_in == MODE_RR) begin
         grant_vld = rr_vld;
         grant_idx = rr_idx;
      end
   end

   // Pointer advances past the winner only on round-robin transfers, so it
   // survives excursions into select mode untouched.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         ptr <= '0;
      end else if (xfer && (mode_in == MODE_RR)) begin
         ptr <= SELW'(rr_next(32'(grant_idx), N_CH));
      end
   end
`else
   logic unused_mode;
   assign unused_mode = mode_in;
   assign grant_vld   = sel_vld;
   assign grant_idx   = sel_idx;
`endif

   // A channel transfer happens whenever the granted source meets a free output.
   assign xfer = !rst_in && load_ok && grant_vld;

   // Route the granted channel's word toward the output register.
   always_comb begin
      grant_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (grant_idx == SELW'(i)) begin
            grant_data = d_in[i*WIDTH +: WIDTH];
         end
      end
   end

   // At most one ready bit: the granted channel, and only when a load can happen.
   always_comb begin
      ready_out = '0;
      if (xfer) begin
         ready_out[grant_idx] = 1'b1;
      end
   end

   // Output register: load on transfer, empty on drain without a new word,
   // hold everything while stalled.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         y_out     <= '0;
         ch_out    <= '0;
         valid_out <= 1'b0;
      end else if (load_ok) begin
         if (grant_vld) begin
            y_out     <= grant_data;
            ch_out    <= grant_idx;
            valid_out <= 1'b1;
         end else begin
            valid_out <= 1'b0;
         end
      end
   end

endmodule
